// File: rtl/fpsu_ret_pkg.sv
// Shared types and constants for the FP add/sub retire-status collector.
package fpsu_ret_pkg;

  localparam int RET_W = 14;

  localparam int FLG_INV = 0;
  localparam int FLG_DZ  = 1;
  localparam int FLG_OF  = 2;
  localparam int FLG_UF  = 3;
  localparam int FLG_NX  = 4;

  typedef enum logic [1:0] {
    PORT_U1 = 2'd0,
    PORT_U3 = 2'd1,
    PORT_U5 = 2'd2
  } port_e;

  typedef struct packed {
    port_e            port;
    logic [RET_W-1:0] ret;
  } ret_ent_t;

endpackage

// File: rtl/fpsu_ret_fifo.sv
// Circular buffer accepting up to three pre-compacted writes and one read per cycle.
module fpsu_ret_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [W-1:0]               wr_data_i [3],
  input  logic [1:0]                 wr_num_i,
  input  logic                       rd_en_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [W-1:0]               rd_data_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] waddr [3];

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      waddr[k] = wptr_q + AW'(k);
    end
    wptr_d  = wptr_q + AW'(wr_num_i);
    rptr_d  = rptr_q + AW'(rd_en_i);
    count_d = count_q + CW'(wr_num_i) - CW'(rd_en_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of block order.
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // NOTE: storage is not reset; validity is tracked by count_q, so stale contents are never visible.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst && (2'(k) < wr_num_i)) begin
        mem[waddr[k]] <= wr_data_i[k];
      end
    end
  end

  assign count_o   = count_q;
  assign rd_data_o = (count_q != '0) ? mem[rptr_q] : '0;

endmodule

// File: rtl/fpsu_ret_collect.sv
// Merges the three FP add/sub retire ports into one ordered, backpressured stream
// with scheduler stall, sticky IEEE flags and a sticky overflow error.
module fpsu_ret_collect #(
  parameter int DEPTH = 8,
  parameter int RET_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RET_W-1:0] u1_ret,
  input  logic             u1_ret_en,
  input  logic [RET_W-1:0] u3_ret,
  input  logic             u3_ret_en,
  input  logic [RET_W-1:0] u5_ret,
  input  logic             u5_ret_en,
  output logic [RET_W-1:0] out_ret,
  output logic [1:0]       out_port,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             stall,
  output logic [4:0]       flags,
  input  logic             flags_clr,
  output logic             ovf_err
);

  import fpsu_ret_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = RET_W + 2;

  logic [CW-1:0] count;
  logic [EW-1:0] head;
  logic [EW-1:0] ent  [3];
  logic [EW-1:0] slot [3];
  logic [2:0]    req;
  logic [1:0]    n_req, n_acc;
  logic [CW:0]   cap;
  logic          deq;
  logic [4:0]    acc_flags;
  logic [4:0]    flags_q, flags_d;
  logic          ovf_q, ovf_d;

  assign req    = {u5_ret_en, u3_ret_en, u1_ret_en};
  assign ent[0] = {2'(PORT_U1), u1_ret};
  assign ent[1] = {2'(PORT_U3), u3_ret};
  assign ent[2] = {2'(PORT_U5), u5_ret};

  assign out_valid = (count != '0);
  assign deq       = out_valid & out_ready;

  // Pack enabled entries to the front in u1, u3, u5 priority order.
  always_comb begin
    n_req = '0;
    for (int i = 0; i < 3; i++) begin
      slot[i] = '0;
    end
    for (int i = 0; i < 3; i++) begin
      if (req[i]) begin
        slot[n_req] = ent[i];
        n_req       = n_req + 2'd1;
      end
    end
  end

  // A slot freed by this cycle's dequeue is reusable in the same cycle.
  always_comb begin
    cap       = (CW+1)'(DEPTH) - {1'b0, count} + (CW+1)'(deq);
    n_acc     = ({{(CW-1){1'b0}}, n_req} > cap) ? cap[1:0] : n_req;
    acc_flags = '0;
    for (int k = 0; k < 3; k++) begin
      if (2'(k) < n_acc) begin
        acc_flags = acc_flags | slot[k][4:0];
      end
    end
    flags_d = (flags_q & ~{5{flags_clr}}) | acc_flags;
    ovf_d   = ovf_q | (n_req != n_acc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      ovf_q   <= ovf_d;
    end
  end

  fpsu_ret_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_data_i (slot),
    .wr_num_i  (n_acc),
    .rd_en_i   (deq),
    .count_o   (count),
    .rd_data_o (head)
  );

  assign out_ret  = head[RET_W-1:0];
  assign out_port = head[EW-1 -: 2];
  assign stall    = (count >= CW'(DEPTH - 2));
  assign flags    = flags_q;
  assign ovf_err  = ovf_q;

endmodule

// File: tb/tb_fpsu_ret_collect.sv
// Randomized scoreboard bench for fpsu_ret_collect against a queue-based reference model.
module tb_fpsu_ret_collect;

  import fpsu_ret_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] u1_ret, u3_ret, u5_ret;
  logic        u1_ret_en, u3_ret_en, u5_ret_en;
  logic [13:0] out_ret;
  logic [1:0]  out_port;
  logic        out_valid, out_ready, stall, ovf_err, flags_clr;
  logic [4:0]  flags;

  fpsu_ret_collect #(.DEPTH(DEPTH), .RET_W(14)) dut (
    .clk       (clk),
    .rst       (rst),
    .u1_ret    (u1_ret),
    .u1_ret_en (u1_ret_en),
    .u3_ret    (u3_ret),
    .u3_ret_en (u3_ret_en),
    .u5_ret    (u5_ret),
    .u5_ret_en (u5_ret_en),
    .out_ret   (out_ret),
    .out_port  (out_port),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .stall     (stall),
    .flags     (flags),
    .flags_clr (flags_clr),
    .ovf_err   (ovf_err)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  ret_ent_t   sb[$];
  int         mcount = 0;
  logic [4:0] mflags = '0;
  logic       movf   = 1'b0;
  bit         mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then apply the buffer rules to the model at the edge.
  task automatic step(input logic rst_v, input logic [2:0] en,
                      input logic [13:0] r1, input logic [13:0] r3, input logic [13:0] r5,
                      input logic rdy, input logic clr);
    logic [13:0] r [3];
    int          cap, acc, deq;
    logic [4:0]  nf;
    rst = rst_v;
    u1_ret = r1; u3_ret = r3; u5_ret = r5;
    {u5_ret_en, u3_ret_en, u1_ret_en} = en;
    out_ready = rdy;
    flags_clr = clr;
    r[0] = r1; r[1] = r3; r[2] = r5;
    @(posedge clk);
    if (rst_v) begin
      sb.delete();
      mcount = 0;
      mflags = '0;
      movf   = 1'b0;
    end else begin
      deq = (mcount > 0 && rdy) ? 1 : 0;
      cap = DEPTH - mcount + deq;
      acc = 0;
      nf  = '0;
      for (int i = 0; i < 3; i++) begin
        if (en[i]) begin
          if (acc < cap) begin
            sb.push_back('{port: port_e'(i), ret: r[i]});
            nf = nf | r[i][4:0];
            acc++;
          end else begin
            movf = 1'b1;
          end
        end
      end
      mcount = mcount + acc - deq;
      mflags = (clr ? 5'd0 : mflags) | nf;
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("valid", 32'(out_valid), 32'(mcount != 0));
      check("stall", 32'(stall), 32'(mcount >= DEPTH - 2));
      check("flags", 32'(flags), 32'(mflags));
      check("ovf_err", 32'(ovf_err), 32'(movf));
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL head: DUT valid with word %0h but model is empty at %0t", out_ret, $time);
        end else begin
          check("out_ret", 32'(out_ret), 32'(sb[0].ret));
          check("out_port", 32'(out_port), 32'(sb[0].port));
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  function automatic logic [13:0] rnd_noflag();
    logic [13:0] v;
    v = 14'($urandom);
    return {v[13:5], 5'b0};
  endfunction

  initial begin
    step(1'b1, 3'b111, 14'h3fff, 14'h3fff, 14'h3fff, 1'b1, 1'b0);
    step(1'b1, 3'b000, '0, '0, '0, 1'b0, 1'b0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ret", 32'(out_ret), 32'd0);
    check("rst_port", 32'(out_port), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_ovf", 32'(ovf_err), 32'd0);
    mon_en = 1'b1;

    // Ordered merge
    step(1'b0, 3'b111, 14'h0021, 14'h0040, 14'h0003, 1'b1, 1'b0);
    check("merge_flags", 32'(flags), 32'h03);
    repeat (4) step(1'b0, 3'b000, '0, '0, '0, 1'b1, 1'b0);

    // Backpressure to count 6, then hold
    step(1'b0, 3'b111, rnd_noflag(), rnd_noflag(), rnd_noflag(), 1'b0, 1'b0);
    step(1'b0, 3'b111, rnd_noflag(), rnd_noflag(), rnd_noflag(), 1'b0, 1'b0);
    check("bp_stall", 32'(stall), 32'd1);
    repeat (2) step(1'b0, 3'b000, '0, '0, '0, 1'b0, 1'b0);

    // Overflow drop: 7 buffered, then all three ports
    step(1'b0, 3'b001, rnd_noflag(), '0, '0, 1'b0, 1'b0);
    step(1'b0, 3'b111, 14'h01a4, 14'h0008, 14'h0010, 1'b0, 1'b0);
    check("ovf_set", 32'(ovf_err), 32'd1);
    check("ovf_flags", 32'(flags), 32'h07);

    // Full with dequeue: single u5 write accepted
    step(1'b0, 3'b100, '0, '0, 14'h0150, 1'b1, 1'b0);
    check("fulldeq_flags", 32'(flags), 32'h17);
    check("fulldeq_stall", 32'(stall), 32'd1);
    repeat (10) step(1'b0, 3'b000, '0, '0, '0, 1'b1, 1'b0);

    // Flag set/clear race, then clear alone
    step(1'b0, 3'b001, 14'h0004, '0, '0, 1'b1, 1'b1);
    check("race_flags", 32'(flags), 32'h04);
    step(1'b0, 3'b000, '0, '0, '0, 1'b1, 1'b1);
    check("clr_flags", 32'(flags), 32'h00);

    // Reset mid-stream with 5 buffered and ovf_err still set
    step(1'b0, 3'b111, 14'($urandom), 14'($urandom), 14'($urandom), 1'b0, 1'b0);
    step(1'b0, 3'b011, 14'($urandom), 14'($urandom), '0, 1'b0, 1'b0);
    step(1'b1, 3'b111, 14'($urandom), 14'($urandom), 14'($urandom), 1'b0, 1'b0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_stall", 32'(stall), 32'd0);
    check("mid_rst_flags", 32'(flags), 32'd0);
    check("mid_rst_ovf", 32'(ovf_err), 32'd0);

    // Randomized traffic with varying backpressure
    for (int seg = 0; seg < 15; seg++) begin
      int rdy_pct;
      case (seg % 3)
        0:       rdy_pct = 10;
        1:       rdy_pct = 50;
        default: rdy_pct = 90;
      endcase
      for (int c = 0; c < 200; c++) begin
        logic [2:0] en;
        en[0] = ($urandom_range(99) < 60);
        en[1] = ($urandom_range(99) < 60);
        en[2] = ($urandom_range(99) < 60);
        step($urandom_range(199) == 0, en,
             14'($urandom), 14'($urandom), 14'($urandom),
             $urandom_range(99) < rdy_pct, $urandom_range(19) == 0);
      end
    end

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpsu_ret_collect.md
# fpsu_ret_collect

Retire-status collector for the FP add/sub SIMD unit. It takes the three per-port retire words (`u1_ret`, `u3_ret`, `u5_ret` with their enables), merges them into one ordered stream, and drains that stream to the retire unit over a valid/ready handshake. It buffers up to DEPTH entries, raises `stall` to the scheduler before the buffer can overflow, and accumulates sticky IEEE exception flags for `fpcsr`.

## Interface
Parameters:
- `DEPTH`, default 8: buffer entries; a power of two, at least 4.
- `RET_W`, default 14: retire word width.

Ports (clock and reset first):
- `clk`  in  1  sole clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `u1_ret`  in  14  port-1 retire word; bits [4:0] are the IEEE flags {inexact, underflow, overflow, divzero, invalid}; bits [13:5] are status/tag.
- `u1_ret_en`  in  1  `u1_ret` is valid this cycle.
- `u3_ret`, `u3_ret_en`  in  14, 1  same as `u1_ret` / `u1_ret_en`, for port 3.
- `u5_ret`, `u5_ret_en`  in  14, 1  same as `u1_ret` / `u1_ret_en`, for port 5.
- `out_ret`  out  14  head entry's retire word.
- `out_port`  out  2  head entry's source port: 0 = u1, 1 = u3, 2 = u5.
- `out_valid`  out  1  head entry present.
- `out_ready`  in  1  consumer accepts the head this cycle.
- `stall`  out  1  scheduler must not issue new FP add/sub operations.
- `flags`  out  5  sticky OR of the IEEE flags of every enqueued entry.
- `flags_clr`  in  1  clear `flags`.
- `ovf_err`  out  1  sticky; set when an entry was dropped.

## Operation
- **Enqueue order within a cycle:** u1, then u3, then u5. Only entries whose `_ret_en` is 1 are written. They occupy consecutive slots from the write pointer.
- **Dequeue:** happens when `out_valid & out_ready`; the read pointer advances by 1.
- **Capacity in a cycle:** `cap = DEPTH - count + deq`. A slot freed by this cycle's dequeue may be reused in the same cycle.
- **Overflow:** if the number of enabled writes exceeds `cap`, the first `cap` entries in the priority order are written. The rest are dropped and `ovf_err` is set. `ovf_err` clears only on `rst`.
- **Occupancy:** `count_next = count + writes_accepted - deq`. `count` is `$clog2(DEPTH)+1` bits wide. Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH.
- **stall:** `stall = (count >= DEPTH-2)`, decoded combinationally from the registered `count`. This guarantees room for three writes on the following cycle.
- **flags:**
  - `flags_next = (flags & ~{5{flags_clr}}) | OR of ret[4:0] over accepted writes`.
  - When set and clear happen in the same cycle, set wins.
  - Dropped entries do not contribute.
- **Stored entry:** `{port[1:0], ret[13:0]}`, 16 bits.

## Timing
- **Reset values:**
  - `out_valid` = 0, `out_ret` = 0, `out_port` = 0.
  - `stall` = 0, `flags` = 0, `ovf_err` = 0.
  - Buffer empty, both pointers 0.
  - Inputs present in the reset cycle are ignored.
  - Reset asserted mid-operation discards all buffered entries on the next edge.
- **Latency:** an entry enabled in cycle N is visible on `out_*` in cycle N+1 at the earliest. There is no bypass from input to output.
- **Handshake:**
  - `out_ret` and `out_port` stay stable while `out_valid & ~out_ready`.
  - `out_valid` does not depend combinationally on `out_ready`.
- **Full buffer with simultaneous dequeue:** capacity is 1. A single write is accepted and `count` stays at DEPTH.
- **Empty buffer:** `out_valid` = 0. `out_ready` is ignored.
- **stall timing:** `stall` is registered-state-derived. It asserts in cycle N+1 after the enqueue in cycle N that takes `count` to DEPTH-2.

## Structure
- **Shared package `fpsu_ret_pkg`:**
  - `RET_W`.
  - Flag bit indices `FLG_INV`=0, `FLG_DZ`=1, `FLG_OF`=2, `FLG_UF`=3, `FLG_NX`=4.
  - Port codes `PORT_U1`=0, `PORT_U3`=1, `PORT_U5`=2.
  - Typedef `ret_ent_t` for the `{port, ret}` entry.
- **Sub-module `fpsu_ret_fifo`:**
  - 3-write, 1-read circular buffer.
  - Takes write-enable compaction and capacity as inputs.
  - Outputs `count`.
- **Top level:** priority compaction, the `cap` computation, flag and overflow logic, and `stall`.

## Test plan
- **Ordered merge:** reset, then `u1_ret`=14'h0021, `u3_ret`=14'h0040, `u5_ret`=14'h0003 all enabled in one cycle, with `out_ready`=1. Required output: those words on `out_ret` over cycles 1, 2, 3, with `out_port` = 0, 1, 2. `flags` = 5'b00011 from cycle 1.
- **Hold under backpressure:** `out_ready`=0 with DEPTH=8, and three writes in each of cycles 0 and 1 (count reaches 6 after cycle 1). Required: `stall`=1 from cycle 2, and `out_ret` unchanged while not ready.
- **Overflow drop:** hold `out_ready`=0, fill the buffer to 7, then enable all three ports. Required: only the u1 entry is stored, `ovf_err`=1, count=8, and the dropped entries' flags do not appear in `flags`.
- **Full with dequeue:** count=8, `out_ready`=1, and only `u5_ret_en` asserted. Required: u5 entry accepted, count stays 8, `ovf_err` unchanged.
- **Flag set/clear race:** `flags_clr`=1 in the same cycle an entry with ret[2]=1 is enqueued. Required: `flags` = 5'b00100 next cycle. With `flags_clr` alone: `flags` = 0.
- **Reset mid-stream:** reset asserted with 5 entries buffered. Required: next cycle `out_valid`=0, `stall`=0, `flags`=0, `ovf_err`=0.
